// File: rtl/wb_grf_pkg.sv
// Shared encodings for the write-back stage; the decoder imports the same enums.
package wb_grf_pkg;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_LUI  = 2'd3
  } wb_sel_e;

  // Codes 5..7 are unused and fall back to a full-word load.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/wb_grf_if.sv
// Write-back/register-file bundle: instruction-side inputs plus read and write-back results.
interface wb_grf_if;
  logic [31:0] PC;
  logic        RegWr;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [1:0]  WBSel;
  logic [31:0] ALURes;
  logic [31:0] MemD;
  logic [15:0] Imm16;
  logic [2:0]  LdType;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WDOut;
  logic [31:0] RetireCnt;

  modport master (
    output PC, RegWr, A1, A2, A3, WBSel, ALURes, MemD, Imm16, LdType,
    input  RD1, RD2, WDOut, RetireCnt
  );

  modport slave (
    input  PC, RegWr, A1, A2, A3, WBSel, ALURes, MemD, Imm16, LdType,
    output RD1, RD2, WDOut, RetireCnt
  );
endinterface

// File: rtl/wb_grf_load_ext.sv
// Load extractor: picks the addressed byte/halfword out of an aligned word and extends it.
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
    input  logic [31:0] mem_d,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_type,
    output logic [31:0] ld_val
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        // Halfword selection ignores off[0]; misaligned halves are not trapped here.
        half = off[1] ? mem_d[31:16] : mem_d[15:0];
        case (off)
            2'd0:    byte_v = mem_d[7:0];
            2'd1:    byte_v = mem_d[15:8];
            2'd2:    byte_v = mem_d[23:16];
            default: byte_v = mem_d[31:24];
        endcase

        ld_val = mem_d;
        case (ld_type)
            LD_H:    ld_val = {{16{half[15]}}, half};
            LD_HU:   ld_val = {16'h0000, half};
            LD_B:    ld_val = {{24{byte_v[7]}}, byte_v};
            LD_BU:   ld_val = {24'h000000, byte_v};
            default: ld_val = mem_d;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Write-back mux, 32x32 register file with same-cycle write bypass, and retired-instruction counter.
module wb_grf
  import wb_grf_pkg::*;
#(
    parameter bit LOG_EN = 1'b1
) (
    input logic   CLK,
    input logic   Reset,
    wb_grf_if.slave bus
);

    logic [31:0] ld_val;
    logic [31:0] wd;
    logic [31:0] regs [NUM_REGS] = '{default: '0};
    logic [31:0] retire_cnt = '0;

    wb_grf_load_ext u_load_ext (
        .mem_d   (bus.MemD),
        .off     (bus.ALURes[1:0]),
        .ld_type (bus.LdType),
        .ld_val  (ld_val)
    );

    always_comb begin
        wd = bus.ALURes;
        case (bus.WBSel)
            WB_ALU:  wd = bus.ALURes;
            WB_MEM:  wd = ld_val;
            WB_LINK: wd = bus.PC + 32'd4;
            WB_LUI:  wd = {bus.Imm16, 16'h0000};
        endcase
    end

    assign bus.WDOut     = wd;
    assign bus.RetireCnt = retire_cnt;

    // Bypass ignores Reset: decode sees this cycle's result even while the array is being cleared.
    assign bus.RD1 = (bus.A1 == 5'd0) ? 32'd0 :
                     (bus.RegWr && bus.A3 == bus.A1) ? wd : regs[bus.A1];
    assign bus.RD2 = (bus.A2 == 5'd0) ? 32'd0 :
                     (bus.RegWr && bus.A3 == bus.A2) ? wd : regs[bus.A2];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            retire_cnt <= '0;
        end else begin
            if (bus.RegWr && bus.A3 != 5'd0) regs[bus.A3] <= wd;
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

`ifndef SYNTHESIS
    generate
        if (LOG_EN) begin : g_log
            always @(posedge CLK) begin
                if (!Reset && bus.RegWr && bus.A3 != 5'd0)
                    $display("@%h: $%d <= %h", bus.PC, bus.A3, wd);
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed plus random bench for wb_grf, checked against an array/arithmetic reference model.
module tb_wb_grf;

    logic CLK = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    wb_grf_if bus ();

    wb_grf #(.LOG_EN(1'b1)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_load(input logic [31:0] mem, input int off, input int lt);
        logic [31:0] b, h;
        b = (mem >> (8 * off)) & 32'hFF;
        h = (mem >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            2:       return h;
            3:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4:       return b;
            default: return mem;
        endcase
    endfunction

    function automatic logic [31:0] m_wd();
        case (bus.WBSel)
            2'd0:    return bus.ALURes;
            2'd1:    return m_load(bus.MemD, int'(bus.ALURes % 4), int'(bus.LdType));
            2'd2:    return bus.PC + 4;
            default: return 32'(bus.Imm16) * 65536;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 0;
        if (bus.RegWr && bus.A3 == a) return m_wd();
        return m_regs[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge with inputs driven; returns at the next negedge.
    task automatic cycle(input string tag);
        logic [31:0] wd;
        #1;
        check({tag, ".rd1"}, bus.RD1, m_rd(bus.A1));
        check({tag, ".rd2"}, bus.RD2, m_rd(bus.A2));
        check({tag, ".wd"}, bus.WDOut, m_wd());
        @(posedge CLK);
        wd = m_wd();
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_cnt = 0;
        end else begin
            if (bus.RegWr && bus.A3 != 0) m_regs[bus.A3] = wd;
            m_cnt = m_cnt + 1;
        end
        #1;
        check({tag, ".cnt"}, bus.RetireCnt, m_cnt);
        @(negedge CLK);
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] a3, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] memd, input logic [15:0] imm, input logic [2:0] lt,
                         input logic [31:0] pc);
        Reset = rst; bus.RegWr = we; bus.A1 = a1; bus.A2 = a2; bus.A3 = a3;
        bus.WBSel = sel; bus.ALURes = alu; bus.MemD = memd; bus.Imm16 = imm;
        bus.LdType = lt; bus.PC = pc;
    endtask

    typedef struct { logic [2:0] lt; logic [1:0] off; logic [31:0] exp; } ld_vec_t;
    ld_vec_t ld_tab [7] = '{
        '{3'd3, 2'd0, 32'h0000_0001}, '{3'd3, 2'd1, 32'h0000_007F},
        '{3'd3, 2'd2, 32'hFFFF_FFFF}, '{3'd3, 2'd3, 32'hFFFF_FF80},
        '{3'd4, 2'd3, 32'h0000_0080}, '{3'd1, 2'd2, 32'hFFFF_80FF},
        '{3'd2, 2'd0, 32'h0000_7F01}
    };

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_cnt = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);

        // Reset state: every address reads 0, counter held at 0.
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, 5'(a), 5'(31 - a), 0, 0, 0, 0, 0, 0, 0);
            cycle("rst_read");
        end
        check("rst_cnt", bus.RetireCnt, 32'd0);

        // Basic ALU write then read-back.
        drive(0, 1, 0, 0, 5, 0, 32'h1234_5678, 0, 0, 0, 32'h0000_3000);
        cycle("wr5");
        drive(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0000_3004);
        #1 check("rd5_const", bus.RD1, 32'h1234_5678);
        cycle("rd5");
        check("cnt_after2", bus.RetireCnt, 32'd2);

        // Load extraction sweep.
        foreach (ld_tab[k]) begin
            drive(0, 0, 0, 0, 0, 1, {30'h1000_0000, ld_tab[k].off}, 32'h80FF_7F01, 0, ld_tab[k].lt, 0);
            #1 check($sformatf("ld%0d", k), bus.WDOut, ld_tab[k].exp);
            cycle("ld");
        end

        // Register 0 is never written.
        drive(0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0000_3008);
        #1 check("r0_same", bus.RD1, 32'd0);
        cycle("r0w");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("r0_next", bus.RD1, 32'd0);
        cycle("r0r");

        // Link write with both ports bypassing.
        drive(0, 1, 31, 31, 31, 2, 0, 0, 0, 0, 32'h0000_3000);
        #1 check("byp_rd1", bus.RD1, 32'h0000_3004);
        check("byp_rd2", bus.RD2, 32'h0000_3004);
        cycle("link");
        drive(0, 0, 31, 31, 0, 0, 0, 0, 0, 0, 0);
        #1 check("link_stored", bus.RD1, 32'h0000_3004);
        cycle("link_rd");

        // lui
        drive(0, 0, 0, 0, 0, 3, 0, 0, 16'hABCD, 0, 0);
        #1 check("lui", bus.WDOut, 32'hABCD_0000);
        cycle("lui");

        // Counter wrap.
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        check("cnt_forced", bus.RetireCnt, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("wrap");
        check("wrap_const", bus.RetireCnt, 32'd0);

        // Reset mid-run drops the concurrent write.
        drive(0, 1, 0, 0, 7, 0, 32'h0000_0055, 0, 0, 0, 0);
        cycle("pre_rst");
        drive(1, 1, 9, 9, 9, 0, 32'h0000_0099, 0, 0, 0, 0);
        #1 check("rst_bypass", bus.RD1, 32'h0000_0099);
        cycle("mid_rst");
        check("mid_rst_cnt", bus.RetireCnt, 32'd0);
        drive(0, 1, 7, 0, 9, 0, 32'h0000_0077, 0, 0, 0, 0);
        #1 check("rst_cleared7", bus.RD1, 32'd0);
        cycle("post_rst_wr");
        check("post_rst_cnt", bus.RetireCnt, 32'd1);
        drive(0, 0, 9, 7, 0, 0, 0, 0, 0, 0, 0);
        #1 check("post_rst_rd9", bus.RD1, 32'h0000_0077);
        cycle("post_rst_rd");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a3;
            a3 = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 19) == 0), 1'($urandom), 
                  ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom),
                  a3, 2'($urandom), $urandom, $urandom, 16'($urandom),
                  3'($urandom), $urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
